// File: rtl/sif_xa_master_if.sv
// SIF X-side access bundle: command and response valid/ready channels plus the X-port pins.
// The master modport faces the initiator; slave is the environment (command source, response sink, responder).
interface sif_xa_master_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ADDR_W-1:0] rsp_addr;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] xa_addr;
    logic [DATA_W-1:0] xa_data_wr;
    logic              xa_wr_s;
    logic              xa_rd_s;
    logic [DATA_W-1:0] xa_data_rd;

    modport master (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_data, rsp_ready, xa_data_rd,
        output cmd_ready, rsp_valid, rsp_addr, rsp_data, xa_addr, xa_data_wr, xa_wr_s, xa_rd_s
    );

    modport slave (
        output cmd_valid, cmd_wr, cmd_addr, cmd_data, rsp_ready, xa_data_rd,
        input  cmd_ready, rsp_valid, rsp_addr, rsp_data, xa_addr, xa_data_wr, xa_wr_s, xa_rd_s
    );
endinterface

// File: rtl/sif_xa_master.sv
// SIF X-port initiator: one command -> one registered strobe; reads answer RD_LAT+1 cycles after the strobe.
// Commands are refused while busy, responses hold until rsp_ready; SIF_XA_TXN_CNT_EN adds wr_cnt/rd_cnt.
module sif_xa_master #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int RD_LAT  = 2,
    parameter int GAP_CYC = 0
) (
    input  logic            clk,
    input  logic            rst,
    sif_xa_master_if.master bus,
    output logic            busy
`ifdef SIF_XA_TXN_CNT_EN
    ,
    output logic [15:0]     wr_cnt,
    output logic [15:0]     rd_cnt
`endif
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RD, RSP, GAP} state_t;

    // Both counters run down to zero, so they are loaded one short of the cycle count they time.
    localparam logic [3:0] RD_LOAD  = 4'(RD_LAT - 1);
    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYC - 1);
    localparam state_t     AFTER_TXN = (GAP_CYC > 0) ? GAP : IDLE;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdat_q, wdat_d;
    logic [DATA_W-1:0] rdat_q, rdat_d;
    logic              wr_s_q, wr_s_d;
    logic              rd_s_q, rd_s_d;
    logic              cmd_acc;
    logic              rsp_hs;

    assign cmd_acc = bus.cmd_valid && bus.cmd_ready;
    assign rsp_hs  = (state_q == RSP) && bus.rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            wr_s_q  <= 1'b0;
            rd_s_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            wr_s_q  <= wr_s_d;
            rd_s_q  <= rd_s_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        wr_s_d  = 1'b0;
        rd_s_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_acc) begin
                    addr_d  = bus.cmd_addr;
                    wdat_d  = bus.cmd_data;
                    wr_s_d  = bus.cmd_wr;
                    rd_s_d  = !bus.cmd_wr;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (wr_s_q) begin
                    state_d = AFTER_TXN;
                    cnt_d   = GAP_LOAD;
                end else begin
                    state_d = WAIT_RD;
                    cnt_d   = RD_LOAD;
                end
            end
            // The cycle in which the counter reads zero is the one where xa_data_rd is valid.
            WAIT_RD: begin
                if (cnt_q == 4'd0) begin
                    rdat_d  = bus.xa_data_rd;
                    state_d = RSP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RSP: begin
                if (rsp_hs) begin
                    state_d = AFTER_TXN;
                    cnt_d   = GAP_LOAD;
                end
            end
            GAP: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cmd_ready  = (state_q == IDLE) && !rst;
    assign bus.rsp_valid  = (state_q == RSP);
    assign bus.rsp_addr   = addr_q;
    assign bus.rsp_data   = rdat_q;
    assign bus.xa_addr    = addr_q;
    assign bus.xa_data_wr = wdat_q;
    assign bus.xa_wr_s    = wr_s_q;
    assign bus.xa_rd_s    = rd_s_q;
    assign busy           = (state_q != IDLE);

`ifdef SIF_XA_TXN_CNT_EN
    logic [15:0] wr_cnt_q;
    logic [15:0] rd_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            if (wr_s_q) wr_cnt_q <= wr_cnt_q + 16'd1;
            if (rsp_hs) rd_cnt_q <= rd_cnt_q + 16'd1;
        end
    end

    assign wr_cnt = wr_cnt_q;
    assign rd_cnt = rd_cnt_q;
`endif
endmodule

// File: tb/tb_sif_xa_master.sv
// Bench for sif_xa_master: three instances (RD_LAT/GAP_CYC = 2/0, 1/0, 5/3) on one clock and reset,
// each with a responder that presents the read value only in the cycle RD_LAT after the strobe.
module tb_sif_xa_master;
    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int LAT_T [N] = '{2, 1, 5};
    localparam int GAP_T [N] = '{0, 0, 3};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          cmd_valid  [N];
    logic          cmd_wr     [N];
    logic [AW-1:0] cmd_addr   [N];
    logic [DW-1:0] cmd_data   [N];
    logic          rsp_ready  [N];
    logic [DW-1:0] rd_val     [N];
    logic [DW-1:0] xa_data_rd [N];
    logic          cmd_ready  [N];
    logic          rsp_valid  [N];
    logic [AW-1:0] rsp_addr   [N];
    logic [DW-1:0] rsp_data   [N];
    logic [AW-1:0] xa_addr    [N];
    logic [DW-1:0] xa_data_wr [N];
    logic          xa_wr_s    [N];
    logic          xa_rd_s    [N];
    logic          busy       [N];
`ifdef SIF_XA_TXN_CNT_EN
    logic [15:0]   wr_cnt     [N];
    logic [15:0]   rd_cnt     [N];
`endif

    int total = 0;
    int bad   = 0;
    int nwr [N];
    int nrd [N];
    int exp_wr [N];
    int exp_rd [N];

    for (genvar g = 0; g < N; g++) begin : gi
        sif_xa_master_if #(.ADDR_W(AW), .DATA_W(DW)) xif ();

        sif_xa_master #(
            .ADDR_W (AW),
            .DATA_W (DW),
            .RD_LAT (LAT_T[g]),
            .GAP_CYC(GAP_T[g])
        ) u_dut (
            .clk   (clk),
            .rst   (rst),
            .bus   (xif),
            .busy  (busy[g])
`ifdef SIF_XA_TXN_CNT_EN
            ,
            .wr_cnt(wr_cnt[g]),
            .rd_cnt(rd_cnt[g])
`endif
        );

        assign xif.cmd_valid  = cmd_valid[g];
        assign xif.cmd_wr     = cmd_wr[g];
        assign xif.cmd_addr   = cmd_addr[g];
        assign xif.cmd_data   = cmd_data[g];
        assign xif.rsp_ready  = rsp_ready[g];
        assign xif.xa_data_rd = xa_data_rd[g];
        assign cmd_ready[g]   = xif.cmd_ready;
        assign rsp_valid[g]   = xif.rsp_valid;
        assign rsp_addr[g]    = xif.rsp_addr;
        assign rsp_data[g]    = xif.rsp_data;
        assign xa_addr[g]     = xif.xa_addr;
        assign xa_data_wr[g]  = xif.xa_data_wr;
        assign xa_wr_s[g]     = xif.xa_wr_s;
        assign xa_rd_s[g]     = xif.xa_rd_s;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Responder: the strobe seen in cycle C arms a countdown; only cycle C+RD_LAT carries rd_val.
    int left [N];
    always @(negedge clk) begin
        for (int g = 0; g < N; g++) begin
            if (left[g] == 1) xa_data_rd[g] = rd_val[g];
            else              xa_data_rd[g] = rd_val[g] ^ 16'($urandom_range(1, 65535));
            if (left[g] > 0) left[g] = left[g] - 1;
            if (xa_rd_s[g] === 1'b1) left[g] = LAT_T[g];
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < N; g++) begin
            if (xa_wr_s[g] === 1'b1) nwr[g]++;
            if (xa_rd_s[g] === 1'b1) nrd[g]++;
            if (xa_wr_s[g] === 1'b1 || xa_rd_s[g] === 1'b1)
                chk("strobe_excl", 32'(xa_wr_s[g] & xa_rd_s[g]), 0);
        end
    end

    // Entered at a negedge; returns at the negedge of the strobe cycle (accept cycle + 1).
    task automatic send(input int g, input logic wr, input logic [15:0] a, input logic [15:0] d,
                        output int acc);
        cmd_valid[g] = 1'b1;
        cmd_wr[g]    = wr;
        cmd_addr[g]  = a;
        cmd_data[g]  = d;
        acc = -1;
        for (int i = 0; i < 64 && acc < 0; i++) begin
            if (cmd_ready[g]) acc = cyc;
            @(negedge clk);
        end
        cmd_valid[g] = 1'b0;
        chk("accept_seen", 32'(acc >= 0), 1);
    endtask

    task automatic do_write(input int g, input logic [15:0] a, input logic [15:0] d);
        int acc;
`ifdef SIF_XA_TXN_CNT_EN
        logic [15:0] w0, r0;
        w0 = wr_cnt[g];
        r0 = rd_cnt[g];
`endif
        send(g, 1'b1, a, d, acc);
        exp_wr[g]++;
        chk("wr_strobe", xa_wr_s[g], 1);
        chk("wr_no_rd", xa_rd_s[g], 0);
        chk("wr_addr", xa_addr[g], a);
        chk("wr_data", xa_data_wr[g], d);
        chk("wr_busy", busy[g], 1);
        chk("wr_ready_lo", cmd_ready[g], 0);
        @(negedge clk);
        chk("wr_one_cycle", xa_wr_s[g], 0);
        chk("wr_addr_hold", xa_addr[g], a);
        chk("wr_ready_after", cmd_ready[g], 32'(GAP_T[g] == 0));
`ifdef SIF_XA_TXN_CNT_EN
        chk("wr_cnt_inc", wr_cnt[g], 16'(w0 + 16'd1));
        chk("rd_cnt_by_wr", rd_cnt[g], r0);
`endif
    endtask

    // stall: cycles rsp_ready stays low once rsp_valid rises; queue: hold a write behind the response.
    task automatic do_read(input int g, input logic [15:0] a, input logic [15:0] d,
                           input int stall, input bit queue);
        int acc, rv;
        bit got;
        logic [15:0] qa, qd;
`ifdef SIF_XA_TXN_CNT_EN
        logic [15:0] w0, r0;
        w0 = wr_cnt[g];
        r0 = rd_cnt[g];
`endif
        qa = ~a;
        qd = ~d;
        rd_val[g]    = d;
        rsp_ready[g] = (stall == 0);
        send(g, 1'b0, a, d ^ 16'h00FF, acc);
        exp_rd[g]++;
        chk("rd_strobe", xa_rd_s[g], 1);
        chk("rd_no_wr", xa_wr_s[g], 0);
        chk("rd_addr", xa_addr[g], a);
        got = 1'b0;
        rv  = 0;
        for (int i = 0; i < 64 && !got; i++) begin
            if (rsp_valid[g]) begin
                got = 1'b1;
                rv  = cyc;
            end else begin
                @(negedge clk);
            end
        end
        chk("rsp_seen", 32'(got), 1);
        chk("rsp_latency", rv - (acc + 1), LAT_T[g] + 1);
        chk("rsp_addr", rsp_addr[g], a);
        chk("rsp_data", rsp_data[g], d);
        for (int s = 0; s < stall; s++) begin
            if (s == 0) begin
                cmd_valid[g] = 1'b1;
                cmd_wr[g]    = 1'b1;
                cmd_addr[g]  = qa;
                cmd_data[g]  = qd;
            end else if (!queue) begin
                cmd_valid[g] = 1'b0;
            end
            @(negedge clk);
            chk("bp_valid", rsp_valid[g], 1);
            chk("bp_data", rsp_data[g], d);
            chk("bp_addr", rsp_addr[g], a);
            chk("bp_ready_lo", cmd_ready[g], 0);
        end
        if (!queue) cmd_valid[g] = 1'b0;
        rsp_ready[g] = 1'b1;
        @(negedge clk);
        chk("rsp_drop", rsp_valid[g], 0);
        chk("ready_after_rsp", cmd_ready[g], 32'(GAP_T[g] == 0));
`ifdef SIF_XA_TXN_CNT_EN
        chk("rd_cnt_inc", rd_cnt[g], 16'(r0 + 16'd1));
        chk("wr_cnt_by_rd", wr_cnt[g], w0);
`endif
        if (queue) begin
            @(negedge clk);
            cmd_valid[g] = 1'b0;
            exp_wr[g]++;
            chk("queued_wr_strobe", xa_wr_s[g], 1);
            chk("queued_wr_addr", xa_addr[g], qa);
            chk("queued_wr_data", xa_data_wr[g], qd);
            @(negedge clk);
            chk("queued_wr_once", xa_wr_s[g], 0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc_prev, stale, g, sel;
        logic [15:0] a, d;

        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            cmd_valid[i] = 1'b0;
            cmd_wr[i]    = 1'b0;
            cmd_addr[i]  = '0;
            cmd_data[i]  = '0;
            rsp_ready[i] = 1'b1;
            rd_val[i]    = '0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk("rst_cmd_ready", cmd_ready[i], 0);
            chk("rst_busy", busy[i], 0);
            chk("rst_wr_s", xa_wr_s[i], 0);
            chk("rst_rd_s", xa_rd_s[i], 0);
            chk("rst_rsp_valid", rsp_valid[i], 0);
            chk("rst_xa_addr", xa_addr[i], 0);
            chk("rst_xa_data_wr", xa_data_wr[i], 0);
            chk("rst_rsp_data", rsp_data[i], 0);
`ifdef SIF_XA_TXN_CNT_EN
            chk("rst_wr_cnt", wr_cnt[i], 0);
            chk("rst_rd_cnt", rd_cnt[i], 0);
`endif
        end
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < N; i++) chk("ready_after_rst", cmd_ready[i], 1);

        do_write(0, 16'h1234, 16'hBEEF);

        do_read(0, 16'h0040, 16'hA5A5, 0, 1'b0);
        do_read(1, 16'h0040, 16'hA5A5, 0, 1'b0);
        do_read(2, 16'h0040, 16'hA5A5, 0, 1'b0);

        do_read(0, 16'h0100, 16'h5A5A, 4, 1'b1);

        // Back-to-back writes into the GAP_CYC=3 instance with cmd_valid held high.
        repeat (4) @(negedge clk);
        cmd_valid[2] = 1'b1;
        cmd_wr[2]    = 1'b1;
        cmd_addr[2]  = 16'h0300;
        cmd_data[2]  = 16'hC000;
        acc_prev = 0;
        for (int w = 0; w < 4; w++) begin
            chk("gap_ready_hi", cmd_ready[2], 1);
            acc = cyc;
            if (w > 0) chk("gap_spacing", acc - acc_prev, 2 + GAP_T[2]);
            acc_prev = acc;
            @(negedge clk);
            exp_wr[2]++;
            chk("gap_strobe", xa_wr_s[2], 1);
            chk("gap_addr", xa_addr[2], 16'h0300 + 16'(w));
            chk("gap_data", xa_data_wr[2], 16'hC000 + 16'(w));
            cmd_addr[2] = 16'h0300 + 16'(w + 1);
            cmd_data[2] = 16'hC000 + 16'(w + 1);
            for (int k = 1; k <= 1 + GAP_T[2]; k++) begin
                if (k > 1) @(negedge clk);
                chk("gap_ready_lo", cmd_ready[2], 0);
            end
            @(negedge clk);
        end
        cmd_valid[2] = 1'b0;

        for (int i = 0; i < 45; i++) begin
            g   = i % N;
            a   = 16'($urandom);
            d   = 16'($urandom);
            sel = int'($urandom_range(0, 1));
            if (sel == 1) do_write(g, a, d);
            else          do_read(g, a, d, int'($urandom_range(0, 3)), 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset in the middle of a read: nothing from the aborted read may surface later.
        repeat (6) @(negedge clk);
        rd_val[0] = 16'h1111;
        send(0, 1'b0, 16'h0077, 16'h0000, acc);
        exp_rd[0]++;
        @(negedge clk);
        chk("pre_rst_busy", busy[0], 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", busy[0], 0);
        chk("async_rst_rd_s", xa_rd_s[0], 0);
        chk("async_rst_wr_s", xa_wr_s[0], 0);
        chk("async_rst_rsp_valid", rsp_valid[0], 0);
        chk("async_rst_cmd_ready", cmd_ready[0], 0);
        chk("async_rst_xa_addr", xa_addr[0], 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        stale = 0;
        for (int i = 0; i < LAT_T[0] + 4; i++) begin
            if (rsp_valid[0]) stale++;
            @(negedge clk);
        end
        chk("stale_rsp", stale, 0);
        do_read(0, 16'h0078, 16'h2222, 1, 1'b0);

        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk("wr_strobe_count", nwr[i], exp_wr[i]);
            chk("rd_strobe_count", nrd[i], exp_rd[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sif_xa_master.md
Name: sif_xa_master

Overview:
- Synthesizable initiator for the SIF X-side access port. It drives xa_addr, xa_data_wr, xa_wr_s and xa_rd_s into a SIF responder, and captures xa_data_rd.
- It turns a valid/ready command stream (write or read) into single-cycle X-port strobes and returns read data on a valid/ready response channel.
- It replaces the testbench driver task wherever RTL (CPU bridge, self-test engine) must master the SIF X port.

Parameters:
- ADDR_W, 16, X-port address width.
- DATA_W, 16, X-port data width.
- RD_LAT, 2, cycles from the xa_rd_s strobe cycle to the cycle xa_data_rd is valid. Legal range 1..15.
- GAP_CYC, 0, idle cycles forced after every transaction before the next command is accepted. Legal range 0..15.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous reset, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  command address.
- cmd_data  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  read response present.
- rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high.
- rsp_addr  out  ADDR_W  address of the read being answered.
- rsp_data  out  DATA_W  captured xa_data_rd.
- xa_addr  out  ADDR_W  X-port address.
- xa_data_wr  out  DATA_W  X-port write data.
- xa_wr_s  out  1  X-port write strobe, one cycle.
- xa_rd_s  out  1  X-port read strobe, one cycle.
- xa_data_rd  in  DATA_W  X-port read data.
- busy  out  1  state other than IDLE.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-high.
- Reset values: every output is 0, except cmd_ready = 1 once rst deasserts; state = IDLE.
- All X-port outputs are registered.
- Reset asserted mid-operation: strobes, rsp_valid and busy drop immediately. Any in-flight read is discarded.
- FSM states: IDLE, ISSUE, WAIT_RD, RSP, GAP.
- cmd_ready = (state == IDLE) and not in reset; it is combinational from state only.
- IDLE: on cmd accept at edge T, latch cmd_addr/cmd_data into xa_addr/xa_data_wr and go to ISSUE.
  - xa_wr_s = cmd_wr or xa_rd_s = ~cmd_wr is high for exactly the cycle after T.
- ISSUE, write: strobe drops next cycle. Go to GAP if GAP_CYC > 0, else IDLE.
- ISSUE, read: start a latency counter; go to WAIT_RD, or directly to the capture point if RD_LAT == 1.
- Read timing: the strobe is high in cycle C. xa_data_rd is sampled at the end of cycle C+RD_LAT. rsp_valid rises in cycle C+RD_LAT+1, with rsp_addr = xa_addr and rsp_data = the sample.
- RSP: rsp_valid, rsp_addr and rsp_data hold stable until rsp_ready.
  - On the handshake, rsp_valid falls next cycle; go to GAP if GAP_CYC > 0, else IDLE.
  - rsp_ready high in the same cycle rsp_valid rises is a valid handshake; rsp_valid lasts one cycle.
- GAP: down-counter loaded with GAP_CYC; go to IDLE when it reaches 0. cmd_ready stays low throughout.
- xa_addr and xa_data_wr hold their last value between transactions and never return to 0 except on reset.
- xa_data_wr is also loaded on reads, with don't-care value.
- xa_wr_s and xa_rd_s are never high in the same cycle.
- Throughput with GAP_CYC = 0: one write per 2 cycles. A read with rsp_ready tied high costs RD_LAT+3 cycles.
- rsp_ready while rsp_valid = 0 is ignored.
- cmd_valid may drop without being accepted; it has no effect.

Optional Feature:
- Macro: SIF_XA_TXN_CNT_EN.
- Defined: adds outputs wr_cnt[15:0] and rd_cnt[15:0], reset 0.
  - wr_cnt increments in each cycle xa_wr_s is high.
  - rd_cnt increments on each response handshake.
  - Both wrap from 0xFFFF to 0x0000.
- Not defined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold rst for 3 cycles mid-read (during WAIT_RD) -> all strobes, rsp_valid and busy = 0 asynchronously; the next read after release returns fresh data and no stale response appears.
- Single write: cmd wr=1, addr 0x1234, data 0xBEEF -> next cycle xa_wr_s = 1 with xa_addr = 0x1234 and xa_data_wr = 0xBEEF, for one cycle only; xa_rd_s stays 0.
- Read latency, RD_LAT = 2: read 0x0040 with the responder model returning 0xA5A5 at C+2 -> rsp_valid at C+3 with rsp_addr = 0x0040 and rsp_data = 0xA5A5. Repeat with RD_LAT = 1 and RD_LAT = 5.
- Backpressure: rsp_ready low for 4 cycles -> rsp_valid/rsp_data stable, cmd_ready = 0 throughout; the queued cmd is accepted 1 cycle after the handshake.
- Gap and back-to-back, GAP_CYC = 3: cmd_valid held high with 4 writes -> strobes spaced exactly 5 cycles apart, cmd_ready low for 4 cycles after each accept.
- Counter build: with SIF_XA_TXN_CNT_EN, preload 0xFFFE writes, then 3 writes -> wr_cnt reads 0xFFFF, 0x0000, 0x0001; rd_cnt is unchanged by writes.
